// File: rtl/csa_serial_adder_pkg.sv
// Shared definitions for the byte-serial adder: FSM state encodings, byte
// width and a helper that sizes the byte index counter.
package csa_serial_adder_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // A one-byte adder still needs a 1-bit index register.
  function automatic int idx_width(input int n_bytes);
    return (n_bytes > 1) ? $clog2(n_bytes) : 1;
  endfunction

endpackage

// File: rtl/csa_serial_adder_csa8.sv
// csa_8: combinational 8-bit carry-select adder.
// The low nibble ripples, and the high nibble is computed for both carry
// values so that the low-nibble carry only drives a final select.
// Ports:
//   a, b   in  8  operands
//   cin    in  1  carry in
//   sum    out 8  a + b + cin (low 8 bits)
//   carry  out 1  carry out of bit 7
module csa_8
  import csa_serial_adder_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              cin,
  output logic [BYTE_W-1:0] sum,
  output logic              carry
);

  logic [4:0] lo;
  logic [4:0] hi0;
  logic [4:0] hi1;

  always_comb begin
    lo    = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0000, cin};
    hi0   = {1'b0, a[7:4]} + {1'b0, b[7:4]};
    hi1   = {1'b0, a[7:4]} + {1'b0, b[7:4]} + 5'd1;
    sum   = {(lo[4] ? hi1[3:0] : hi0[3:0]), lo[3:0]};
    carry = lo[4] ? hi1[4] : hi0[4];
  end

endmodule

// File: rtl/csa_serial_adder.sv
// csa_serial_adder: multi-byte adder that sequences operands through one
// csa_8, one byte per clock, LSB byte first, with the carry registered
// between bytes. Valid/ready handshake on both sides.
//
// Ports:
//   CLK, RST_N            clock (rising edge), async active-low reset
//   IN_VALID / IN_READY   operand handshake (A, B, CIN captured on accept)
//   OUT_VALID / OUT_READY result handshake (SUM, CARRY, OVF held until taken)
//   SUM, CARRY            {CARRY,SUM} = A + B + CIN
//   OVF                   signed overflow; real logic only when the macro
//                         CSA_OVF_FLAG_EN is defined, otherwise tied to 0
//
// state  | meaning
// S_IDLE | ready for operands; SUM/CARRY hold last result
// S_ADD  | one byte per cycle through csa_8, idx counts up
// S_DONE | result valid, waiting for OUT_READY
module csa_serial_adder
  import csa_serial_adder_pkg::*;
#(
  parameter int N_BYTES = 4
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    IN_VALID,
  output logic                    IN_READY,
  input  logic [8*N_BYTES-1:0]    A,
  input  logic [8*N_BYTES-1:0]    B,
  input  logic                    CIN,
  output logic                    OUT_VALID,
  input  logic                    OUT_READY,
  output logic [8*N_BYTES-1:0]    SUM,
  output logic                    CARRY,
  output logic                    OVF
);

  localparam int W     = BYTE_W * N_BYTES;
  localparam int IDX_W = idx_width(N_BYTES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_BYTES - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             cy_q, cy_d;
  logic             carry_q, carry_d;

  logic [BYTE_W-1:0] a_byte;
  logic [BYTE_W-1:0] b_byte;
  logic [BYTE_W-1:0] byte_sum;
  logic              byte_carry;
  logic              last_byte;

  assign a_byte    = a_q[int'(idx_q)*BYTE_W +: BYTE_W];
  assign b_byte    = b_q[int'(idx_q)*BYTE_W +: BYTE_W];
  assign last_byte = (state_q == S_ADD) && (idx_q == IDX_LAST);

  csa_8 u_csa_8 (
    .a     (a_byte),
    .b     (b_byte),
    .cin   (cy_q),
    .sum   (byte_sum),
    .carry (byte_carry)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    cy_d      = cy_q;
    carry_d   = carry_q;
    IN_READY  = 1'b0;
    OUT_VALID = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        IN_READY = 1'b1;
        if (IN_VALID) begin
          a_d     = A;
          b_d     = B;
          cy_d    = CIN;
          idx_d   = '0;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        sum_d[int'(idx_q)*BYTE_W +: BYTE_W] = byte_sum;
        cy_d  = byte_carry;
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_LAST) begin
          carry_d = byte_carry;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        OUT_VALID = 1'b1;
        if (OUT_READY) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cy_q    <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cy_q    <= cy_d;
      carry_q <= carry_d;
    end
  end

  assign SUM   = sum_q;
  assign CARRY = carry_q;

`ifdef CSA_OVF_FLAG_EN
  logic ovf_q, ovf_d;

  // The final result's sign bit is the byte adder's MSB on the last byte,
  // so the flag is resolved in the same cycle the top byte is written.
  always_comb begin
    ovf_d = ovf_q;
    if (last_byte)
      ovf_d = (a_q[W-1] == b_q[W-1]) && (byte_sum[BYTE_W-1] != a_q[W-1]);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign OVF = ovf_q;
`else
  logic unused_last;
  assign unused_last = last_byte;
  assign OVF = 1'b0;
`endif

endmodule

// File: tb/tb_csa_serial_adder.sv
module tb_csa_serial_adder;
  localparam int N_BYTES = 4;
  localparam int W       = 8 * N_BYTES;
`ifdef CSA_OVF_FLAG_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic         CLK = 1'b0;
  logic         RST_N;
  logic         IN_VALID;
  logic         IN_READY;
  logic [W-1:0] A, B;
  logic         CIN;
  logic         OUT_VALID;
  logic         OUT_READY;
  logic [W-1:0] SUM;
  logic         CARRY;
  logic         OVF;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 CLK = ~CLK;

  csa_serial_adder #(.N_BYTES(N_BYTES)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .A         (A),
    .B         (B),
    .CIN       (CIN),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .SUM       (SUM),
    .CARRY     (CARRY),
    .OVF       (OVF)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] exp_sum;
    logic         exp_carry;
    logic         exp_ovf_en;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference: plain wide arithmetic, {ovf, carry, sum}.
  function automatic logic [W+1:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin);
    logic [W:0] t;
    logic       o;
    t = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    o = OVF_EN && (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
    return {o, t};
  endfunction

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    @(negedge CLK);
    while (!IN_READY && n < 20) begin
      @(negedge CLK);
      n++;
    end
    if (!IN_READY) chk({name, "_in_ready_timeout"}, 64'(IN_READY), 64'd1);
  endtask

  // One full transaction with OUT_READY=1; returns result and accept-to-valid latency.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        output logic [W-1:0] s, output logic c, output logic o,
                        output int lat);
    wait_ready("run_op");
    A = a; B = b; CIN = cin; IN_VALID = 1'b1;
    @(posedge CLK);
    #1;
    IN_VALID = 1'b0;
    A = $urandom; B = $urandom; CIN = 1'($urandom);
    lat = 0;
    do begin
      @(posedge CLK);
      #1;
      lat++;
    end while (!OUT_VALID && lat < 20);
    s = SUM; c = CARRY; o = OVF;
  endtask

  vec_t         vecs[8];
  logic [W-1:0] s;
  logic         c, o;
  int           lat;
  logic [W+1:0] r;

  initial begin
    vecs[0] = '{32'h0000_0000, 32'h0000_0001, 1'b0, 32'h0000_0001, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[2] = '{32'h7777_7777, 32'h5555_5555, 1'b0, 32'hCCCC_CCCC, 1'b0, 1'b1};
    vecs[3] = '{32'h1234_5678, 32'h0000_0000, 1'b1, 32'h1234_5679, 1'b0, 1'b0};
    vecs[4] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[6] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
    vecs[7] = '{32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 32'h8000_0000, 1'b0, 1'b1};

    RST_N = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b1;
    A = '0; B = '0; CIN = 1'b0;
    #2;
    chk("rst_sum", 64'(SUM), 64'd0);
    chk("rst_carry", 64'(CARRY), 64'd0);
    chk("rst_out_valid", 64'(OUT_VALID), 64'd0);
    chk("rst_ovf", 64'(OVF), 64'd0);
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
    chk("rst_in_ready", 64'(IN_READY), 64'd1);

    // Directed table
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, s, c, o, lat);
      chk($sformatf("vec%0d_sum", i), 64'(s), 64'(vecs[i].exp_sum));
      chk($sformatf("vec%0d_carry", i), 64'(c), 64'(vecs[i].exp_carry));
      chk($sformatf("vec%0d_ovf", i), 64'(o), 64'(vecs[i].exp_ovf_en & OVF_EN));
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(N_BYTES));
    end

    // Stall during ADD, then backpressure in DONE
    wait_ready("stall");
    OUT_READY = 1'b0;
    A = 32'h1234_5678; B = 32'h0; CIN = 1'b1; IN_VALID = 1'b1;
    @(posedge CLK);
    #1;
    A = 32'hDEAD_BEEF; B = 32'h0BAD_F00D; CIN = 1'b0;
    for (int i = 0; i < N_BYTES; i++) begin
      @(negedge CLK);
      chk($sformatf("stall_in_ready_add%0d", i), 64'(IN_READY), 64'd0);
    end
    IN_VALID = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk($sformatf("bp_out_valid%0d", i), 64'(OUT_VALID), 64'd1);
      chk($sformatf("bp_sum%0d", i), 64'(SUM), 64'h1234_5679);
      chk($sformatf("bp_in_ready%0d", i), 64'(IN_READY), 64'd0);
    end
    OUT_READY = 1'b1;
    @(negedge CLK);
    chk("bp_release_in_ready", 64'(IN_READY), 64'd1);
    chk("bp_release_out_valid", 64'(OUT_VALID), 64'd0);

    // Reset in the second ADD cycle
    wait_ready("midrst");
    A = 32'h1111_1111; B = 32'h2222_2222; CIN = 1'b0; IN_VALID = 1'b1;
    @(posedge CLK);
    #1;
    IN_VALID = 1'b0;
    @(posedge CLK);
    #1;
    chk("midrst_partial_byte0", 64'(SUM[7:0]), 64'h33);
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    chk("midrst_sum", 64'(SUM), 64'd0);
    chk("midrst_carry", 64'(CARRY), 64'd0);
    chk("midrst_out_valid", 64'(OUT_VALID), 64'd0);
    chk("midrst_ovf", 64'(OVF), 64'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    run_op(32'h0000_FFFF, 32'h0000_0001, 1'b0, s, c, o, lat);
    chk("postrst_sum", 64'(s), 64'h0001_0000);
    chk("postrst_carry", 64'(c), 64'd0);
    chk("postrst_latency", 64'(lat), 64'(N_BYTES));

    // Random operands against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      logic         rc;
      ra = $urandom; rb = $urandom; rc = 1'($urandom);
      if (i % 8 == 0) ra = '1;
      r = ref_add(ra, rb, rc);
      run_op(ra, rb, rc, s, c, o, lat);
      chk($sformatf("rnd%0d_sum", i), 64'(s), 64'(r[W-1:0]));
      chk($sformatf("rnd%0d_carry", i), 64'(c), 64'(r[W]));
      chk($sformatf("rnd%0d_ovf", i), 64'(o), 64'(r[W+1]));
      chk($sformatf("rnd%0d_latency", i), 64'(lat), 64'(N_BYTES));
    end

    @(negedge CLK);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed",
             pass_cnt, total_cnt);
    $fatal(1, "timeout");
  end

endmodule
